// File: rtl/lmdpl_dualrail_decoder.sv
`default_nettype none
// ============================================================================
// Module      : lmdpl_dualrail_decoder
// Description : Receive side of the LMDPL masked dual-rail interface.
//               Registers W rail pairs and runs precharge/evaluate
//               completion detection. It checks each codeword, removes the
//               Boolean output mask and presents the plain result on a
//               valid/ready handshake.
//               Optional: define LMDPL_DEC_ERR_CNT_EN to add a saturating
//               16-bit err_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module lmdpl_dualrail_decoder #(
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mask_valid,
  input  logic [W-1:0] mask_in,
  input  logic [W-1:0] q_m,
  input  logic [W-1:0] q_m_bar,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         err,
  output logic [1:0]   err_code
`ifdef LMDPL_DEC_ERR_CNT_EN
  ,
  output logic [15:0]  err_count
`endif
);

  localparam int             CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  c_TIMEOUT   = CW'(TIMEOUT);
  localparam logic [CW-1:0]  c_CNT_ONE   = CW'(1);
  localparam logic [1:0]     c_ERR_PRE   = 2'b01;
  localparam logic [1:0]     c_ERR_BAD   = 2'b10;
  localparam logic [1:0]     c_ERR_EVAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_EVAL = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [CW-1:0] r_cnt,      w_cnt_nxt;
  logic [W-1:0]  r_mask,     w_mask_nxt;
  logic [W-1:0]  r_out_data, w_out_data_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_err,      w_err_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic [W-1:0]  r_q, r_qb;

  // Per-bit rail classification, computed from the registered rails only
  logic [W-1:0]  w_pre, w_done, w_bad;
  logic [CW-1:0] w_cnt_inc;

  assign w_pre     = ~(r_q | r_qb);
  assign w_done    = r_q ^ r_qb;
  assign w_bad     = r_q & r_qb;
  assign w_cnt_inc = r_cnt + c_CNT_ONE;

  // Single input register stage for the rails; isolates the FSM from the gate array
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_qb <= '0;
    end else begin
      r_q  <= q_m;
      r_qb <= q_m_bar;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err       <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
    end
  end

  // Next-state and next-output decode; err defaults low so it is a one-cycle pulse
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mask_nxt      = r_mask;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = r_err_code;

    case (r_state)
      S_IDLE: begin
        if (mask_valid) begin
          w_mask_nxt  = mask_in;
          w_cnt_nxt   = '0;
          w_state_nxt = S_PRE;
        end
      end

      S_PRE: begin
        if (&w_pre) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_EVAL;
        end else if (w_cnt_inc == c_TIMEOUT) begin
          w_cnt_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = c_ERR_PRE;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_EVAL: begin
        // An invalid codeword outranks completion seen in the same sample
        if (|w_bad) begin
          w_cnt_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = c_ERR_BAD;
          w_state_nxt    = S_IDLE;
        end else if (&w_done) begin
          w_cnt_nxt       = '0;
          w_out_data_nxt  = r_q ^ r_mask;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_OUT;
        end else if (w_cnt_inc == c_TIMEOUT) begin
          w_cnt_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = c_ERR_EVAL;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_OUT: begin
        // A new mask is only taken on the accepting cycle, enabling back-to-back use
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (mask_valid) begin
            w_mask_nxt  = mask_in;
            w_cnt_nxt   = '0;
            w_state_nxt = S_PRE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign busy      = (r_state != S_IDLE);

`ifdef LMDPL_DEC_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Saturating error counter, updated on the same edge that raises err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_err_nxt && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lmdpl_dualrail_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lmdpl_dualrail_decoder
// Description : Self-checking bench for lmdpl_dualrail_decoder (W=4,
//               TIMEOUT=8). It runs directed scenarios followed by random
//               transactions. Expected results come from the transaction
//               rule result = masked_value ^ mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lmdpl_dualrail_decoder;

  localparam int W       = 4;
  localparam int TIMEOUT = 8;

  logic         clk;
  logic         rst_n;
  logic         mask_valid;
  logic [W-1:0] mask_in;
  logic [W-1:0] q_m;
  logic [W-1:0] q_m_bar;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         err;
  logic [1:0]   err_code;
`ifdef LMDPL_DEC_ERR_CNT_EN
  logic [15:0]  err_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  lmdpl_dualrail_decoder #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_valid (mask_valid),
    .mask_in    (mask_in),
    .q_m        (q_m),
    .q_m_bar    (q_m_bar),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err),
    .err_code   (err_code)
`ifdef LMDPL_DEC_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a transaction with precharged rails and walk it to S_EVAL
  task automatic start_to_eval(input logic [W-1:0] m);
    mask_valid = 1'b1; mask_in = m; q_m = '0; q_m_bar = '0;
    tick();
    mask_valid = 1'b0;
    tick();
  endtask

  // One random transaction: stalled precharge, partial evaluation, random ready delay
  task automatic rand_txn(input int idx);
    logic [W-1:0] m, v, en, hold;
    int d, k, r, b, n;
    m = W'($urandom); v = W'($urandom);
    d = $urandom_range(0, 4);
    q_m = v; q_m_bar = ~v;
    mask_valid = 1'b1; mask_in = m;
    tick();
    mask_valid = 1'b0;
    repeat (d) tick();
    q_m = '0; q_m_bar = '0;
    tick(); tick();
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      en = W'($urandom);
      b  = $urandom_range(0, W - 1);
      en[b] = 1'b0;
      q_m = v & en; q_m_bar = ~v & en;
      tick();
    end
    q_m = v; q_m_bar = ~v;
    n = 0;
    while (!out_valid && !err && n < 8) begin
      tick();
      n++;
    end
    chk($sformatf("rand%0d_valid", idx), 16'(out_valid), 16'd1);
    chk($sformatf("rand%0d_data", idx), 16'(out_data), 16'(v ^ m));
    hold = out_data;
    r = $urandom_range(0, 3);
    repeat (r) tick();
    chk($sformatf("rand%0d_hold", idx), 16'(out_data), 16'(hold));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("rand%0d_drop", idx), 16'({out_valid, busy}), 16'd0);
  endtask

  initial begin
    int exp_errs;
    exp_errs   = 0;
    rst_n      = 1'b0;
    mask_valid = 1'b0;
    mask_in    = '0;
    q_m        = '0;
    q_m_bar    = '0;
    out_ready  = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_data", 16'(out_data), 16'd0);
    chk("rst_flags", 16'({out_valid, busy, err}), 16'd0);
    chk("rst_err_code", 16'(err_code), 16'd0);
`ifdef LMDPL_DEC_ERR_CNT_EN
    chk("rst_err_count", err_count, 16'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic transaction and latency
    start_to_eval(4'b1010);
    chk("t1_busy", 16'(busy), 16'd1);
    q_m = 4'b0110; q_m_bar = 4'b1001;
    tick();
    chk("t1_not_yet", 16'(out_valid), 16'd0);
    tick();
    chk("t1_valid", 16'(out_valid), 16'd1);
    chk("t1_data", 16'(out_data), 16'(4'b1100));

    // Back-pressure holds the result
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t2_hold%0d", i), 16'({out_valid, busy, out_data}), 16'({1'b1, 1'b1, 4'b1100}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_release", 16'({out_valid, busy}), 16'd0);

    // Invalid codeword on bit 2
    start_to_eval(4'b0011);
    q_m = 4'b0110; q_m_bar = 4'b1101;
    tick();
    chk("t3_pre_err", 16'(err), 16'd0);
    tick();
    exp_errs++;
    chk("t3_err", 16'({err, err_code, out_valid, busy}), 16'({1'b1, 2'b10, 1'b0, 1'b0}));
`ifdef LMDPL_DEC_ERR_CNT_EN
    chk("t3_err_count", err_count, 16'(exp_errs));
`endif
    tick();
    chk("t3_pulse", 16'({err, err_code}), 16'({1'b0, 2'b10}));

    // Precharge never happens
    q_m = 4'b0000; q_m_bar = 4'b1111;
    mask_valid = 1'b1; mask_in = 4'b0101;
    tick();
    mask_valid = 1'b0;
    repeat (7) tick();
    chk("t4a_before", 16'({err, busy}), 16'({1'b0, 1'b1}));
    tick();
    exp_errs++;
    chk("t4a_err", 16'({err, err_code, busy}), 16'({1'b1, 2'b01, 1'b0}));
`ifdef LMDPL_DEC_ERR_CNT_EN
    chk("t4a_err_count", err_count, 16'(exp_errs));
`endif

    // Evaluation never happens
    start_to_eval(4'b1001);
    repeat (7) tick();
    chk("t4b_before", 16'({err, busy}), 16'({1'b0, 1'b1}));
    tick();
    exp_errs++;
    chk("t4b_err", 16'({err, err_code, busy}), 16'({1'b1, 2'b11, 1'b0}));
`ifdef LMDPL_DEC_ERR_CNT_EN
    chk("t4b_err_count", err_count, 16'(exp_errs));
`endif

    // Back-to-back transactions
    start_to_eval(4'b1111);
    q_m = 4'b0101; q_m_bar = 4'b1010;
    tick(); tick();
    chk("t5a_data", 16'({out_valid, out_data}), 16'({1'b1, 4'b1010}));
    out_ready = 1'b1; mask_valid = 1'b1; mask_in = 4'b0001;
    q_m = '0; q_m_bar = '0;
    tick();
    out_ready = 1'b0; mask_valid = 1'b0;
    chk("t5_no_idle", 16'({out_valid, busy}), 16'({1'b0, 1'b1}));
    tick();
    q_m = 4'b1001; q_m_bar = 4'b0110;
    tick(); tick();
    chk("t5b_data", 16'({out_valid, out_data}), 16'({1'b1, 4'b1000}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of evaluation
    start_to_eval(4'b0110);
    chk("t6_in_eval", 16'(busy), 16'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_out_data", 16'(out_data), 16'd0);
    chk("t6_flags", 16'({out_valid, busy, err, err_code}), 16'd0);
`ifdef LMDPL_DEC_ERR_CNT_EN
    chk("t6_err_count", err_count, 16'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("t6_after", 16'({err, busy}), 16'd0);

    // Random transactions against the unmasking rule
    for (int t = 0; t < 24; t++) rand_txn(t);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
